// File: rtl/lcd_cmd_issuer.sv
// lcd_cmd_issuer: walks a fixed-length command list held in a synchronous
// command ROM and hands each command to LCD_CTRL over cmd/cmd_valid/busy.
// After the last command is accepted, it waits for LCD_CTRL's done pulse
// under a watchdog.
module lcd_cmd_issuer #(
  parameter int CMD_W   = 3,
  parameter int N_CMD   = 45,
  parameter int CA_W    = 6,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             CROM_CEN,
  output logic [CA_W-1:0]  CROM_A,
  input  logic [CMD_W-1:0] CROM_Q,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic [6:0]       issued,
  output logic             seq_done,
  output logic             seq_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CA_W-1:0] LAST_IDX = CA_W'(N_CMD - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAITQ,
    ISSUE,
    DRAIN,
    FINISH,
    ERROR
  } state_t;

  state_t           state, state_nx;
  logic [CA_W-1:0]  idx, idx_nx;
  logic [WD_W-1:0]  wd, wd_nx;
  logic [CMD_W-1:0] cmd_nx;
  logic             cmd_valid_nx;
  logic [6:0]       issued_nx;
  logic             seq_done_nx;
  logic             seq_err_nx;

  // ROM port: enabled only in FETCH. The index stops at the last entry, so
  // CROM_A never leaves the command list.
  always_comb begin
    CROM_CEN = (state != FETCH);
    CROM_A   = idx;
  end

  // State register and registered outputs; reset withdraws everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      wd        <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      issued    <= '0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      wd        <= wd_nx;
      cmd       <= cmd_nx;
      cmd_valid <= cmd_valid_nx;
      issued    <= issued_nx;
      seq_done  <= seq_done_nx;
      seq_err   <= seq_err_nx;
    end
  end

  // Next-state and next-output logic for the fetch / issue / drain sequence.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    wd_nx        = wd;
    cmd_nx       = cmd;
    cmd_valid_nx = cmd_valid;
    issued_nx    = issued;
    seq_done_nx  = seq_done;
    seq_err_nx   = seq_err;

    case (state)
      IDLE, FINISH, ERROR: begin
        if (start) begin
          state_nx    = FETCH;
          idx_nx      = '0;
          wd_nx       = '0;
          issued_nx   = '0;
          seq_done_nx = 1'b0;
          seq_err_nx  = 1'b0;
        end
      end

      FETCH: state_nx = WAITQ;

      WAITQ: begin
        cmd_nx       = CROM_Q;
        cmd_valid_nx = 1'b1;
        state_nx     = ISSUE;
      end

      ISSUE: begin
        if (!busy) begin
          cmd_valid_nx = 1'b0;
          issued_nx    = issued + 7'd1;
          if (idx == LAST_IDX) begin
            wd_nx    = '0;
            state_nx = DRAIN;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = FETCH;
          end
        end
      end

      // done wins over watchdog expiry on the same edge
      DRAIN: begin
        if (done) begin
          seq_done_nx = 1'b1;
          state_nx    = FINISH;
        end else if (wd == WD_LAST) begin
          seq_err_nx = 1'b1;
          state_nx   = ERROR;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  a_cmd_hold: assert property (@(posedge clk) disable iff (reset)
    (cmd_valid && busy) |=> (cmd_valid && $stable(cmd)));

  a_addr_range: assert property (@(posedge clk) disable iff (reset)
    (CROM_A <= LAST_IDX));

  a_issued_range: assert property (@(posedge clk) disable iff (reset)
    (issued <= 7'(N_CMD)));

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Bench for lcd_cmd_issuer: ROM holding addr mod 8, a transaction-level
// model checked every cycle, and directed scenarios with literal checks.
module tb_lcd_cmd_issuer;

  localparam int CMD_W   = 3;
  localparam int N_CMD   = 45;
  localparam int CA_W    = 6;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy = 1'b0;
  logic             done = 1'b0;
  logic             CROM_CEN;
  logic [CA_W-1:0]  CROM_A;
  logic [CMD_W-1:0] CROM_Q = '0;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic [6:0]       issued;
  logic             seq_done;
  logic             seq_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  lcd_cmd_issuer #(
    .CMD_W  (CMD_W),
    .N_CMD  (N_CMD),
    .CA_W   (CA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .CROM_CEN (CROM_CEN),
    .CROM_A   (CROM_A),
    .CROM_Q   (CROM_Q),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .busy     (busy),
    .done     (done),
    .issued   (issued),
    .seq_done (seq_done),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous command ROM: entry k holds k mod 8
  always @(posedge clk) if (!CROM_CEN) CROM_Q <= CROM_A[2:0];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a sequence is a chain of 3-cycle command slots (fetch, ROM wait,
  // present), where presentation stretches while busy; then a drain window.
  // mode: 0 idle, 1 running, 2 draining, 3 finished, 4 error
  int         m_mode = 0;
  int         m_age = 0;
  int         m_issued = 0;
  int         m_dc = 0;
  logic [2:0] m_cmd = '0;
  bit         m_done = 0;
  bit         m_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_age = 0; m_issued = 0; m_dc = 0;
      m_cmd = '0; m_done = 0; m_err = 0;
    end else begin
      case (m_mode)
        0, 3, 4: if (start) begin
          m_mode = 1; m_age = 0; m_issued = 0; m_done = 0; m_err = 0;
        end
        1: begin
          if (m_age == 0) m_age = 1;
          else if (m_age == 1) begin
            m_cmd = 3'(m_issued % 8);
            m_age = 2;
          end else if (!busy) begin
            m_issued++;
            m_age = 0;
            if (m_issued == N_CMD) begin
              m_mode = 2;
              m_dc = 0;
            end
          end
        end
        2: begin
          if (done) begin
            m_mode = 3; m_done = 1;
          end else if (m_dc == TIMEOUT - 1) begin
            m_mode = 4; m_err = 1;
          end else m_dc++;
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    bit e_cen;
    e_cen = !(m_mode == 1 && m_age == 0);
    chk("m_crom_cen", int'(CROM_CEN), int'(e_cen));
    if (!e_cen) chk("m_crom_a", int'(CROM_A), (m_issued < N_CMD) ? m_issued : N_CMD - 1);
    chk("m_cmd", int'(cmd), int'(m_cmd));
    chk("m_cmd_valid", int'(cmd_valid), (m_mode == 1 && m_age >= 2) ? 1 : 0);
    chk("m_issued", int'(issued), m_issued);
    chk("m_seq_done", int'(seq_done), int'(m_done));
    chk("m_seq_err", int'(seq_err), int'(m_err));
  end

  // Log of accepted commands, used for the first full run only
  bit          log_en = 0;
  logic [2:0]  acc_log[$];
  always @(negedge clk) if (log_en && cmd_valid && !busy) acc_log.push_back(cmd);

  int s_cyc;

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_cyc = cyc;
  endtask

  // kind 0: issued==n (and cmd_valid if need_valid); kind 1: seq_err high
  task automatic wait_for(input int kind, input int n, input bit need_valid,
                          input int lim, input string nm);
    int  i = 0;
    bit  hit;
    do begin
      @(negedge clk);
      i++;
      if (kind == 0) hit = (int'(issued) == n) && (!need_valid || cmd_valid);
      else           hit = seq_err;
    end while (!hit && i < lim);
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: condition not reached within %0d cycles", nm, lim);
    end
  endtask

  int e_cyc;
  logic [2:0] hold_cmd;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cen", int'(CROM_CEN), 1);
    chk("rst_a", int'(CROM_A), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_issued", int'(issued), 0);
    chk("rst_flags", int'({seq_done, seq_err}), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Full run, busy low: 45 accepts in 135 cycles, in ROM order
    log_en = 1;
    pulse_start();
    @(negedge clk);
    chk("a_fetch_first", int'(CROM_CEN), 0);
    wait_for(0, 45, 0, 400, "a_all_issued");
    chk("a_run_cycles", cyc - s_cyc, 135);
    log_en = 0;
    chk("a_log_size", acc_log.size(), 45);
    for (int k = 0; k < 5; k++) chk("a_order", int'(acc_log[k]), k);
    chk("a_order_last", int'(acc_log[44]), 4);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("a_seq_done", int'(seq_done), 1);
    chk("a_seq_err", int'(seq_err), 0);

    // Busy stall on command 5, then watchdog expiry
    pulse_start();
    wait_for(0, 5, 1, 100, "b_reach_cmd5");
    busy = 1'b1;
    hold_cmd = cmd;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("b_stall_valid", int'(cmd_valid), 1);
      chk("b_stall_cmd", int'(cmd), int'(hold_cmd));
      chk("b_stall_cen", int'(CROM_CEN), 1);
      chk("b_stall_issued", int'(issued), 5);
    end
    chk("b_cmd5_value", int'(hold_cmd), 5);
    busy = 1'b0;
    @(negedge clk);
    chk("b_accept", int'(issued), 6);
    wait_for(0, 45, 0, 400, "b_all_issued");
    e_cyc = cyc;
    wait_for(1, 0, 0, 40, "b_wd_expire");
    chk("b_wd_cycles", cyc - e_cyc, 16);
    chk("b_no_done", int'(seq_done), 0);
    pulse_start();
    @(negedge clk);
    chk("b_err_clear", int'(seq_err), 0);
    chk("b_issued_restart", int'(issued), 0);

    // done during ISSUE of command 3 ignored; done coincides with expiry
    wait_for(0, 3, 1, 100, "c_reach_cmd3");
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("c_no_done_flag", int'(seq_done), 0);
    wait_for(0, 45, 0, 400, "c_all_issued");
    repeat (15) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("c_tie_done", int'(seq_done), 1);
    chk("c_tie_err", int'(seq_err), 0);

    // Reset at command 20 with cmd_valid high; start during reset ignored
    pulse_start();
    wait_for(0, 20, 1, 200, "d_reach_cmd20");
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("d_rst_valid", int'(cmd_valid), 0);
    chk("d_rst_issued", int'(issued), 0);
    chk("d_rst_cen", int'(CROM_CEN), 1);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("d_idle_cen", int'(CROM_CEN), 1);
      chk("d_idle_valid", int'(cmd_valid), 0);
    end
    pulse_start();
    @(negedge clk);
    chk("d_restart_fetch", int'(CROM_CEN), 0);
    wait_for(0, 45, 0, 400, "d_all_issued");
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("d_seq_done", int'(seq_done), 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
